dff_trace_capture: RTL and testbench
====================================

Name: dff_trace_capture

Overview:
- Hardware response recorder for the flip-flop test harness: stores per-step snapshots of the DUT's control inputs and output, then replays them in order to a downstream reader.
- Sits beside the DUT. Stimulus logic drives vec_in plus a step strobe; a logger or comparator drains the trace over a valid/ready port.
- Also keeps a running 16-bit signature, so pass/fail can be decided without draining.

Parameters:
- DEPTH, 16, number of trace entries (power of two, 2..256).
- WIDTH, 4, bits per trace entry.
- ADDR_W, $clog2(DEPTH), derived; not overridden by users.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- arm  in  1  single-cycle start request.
- sample_en  in  1  qualifies the current cycle as a capture step.
- vec_in  in  WIDTH  snapshot bits: [3] DUT reset, [2] enable, [1] d, [0] q.
- num_samples  in  ADDR_W+1  capture length, latched at arm.
- busy  out  1  high in CAPTURE or DRAIN.
- done  out  1  high in DONE; sticky until next arm or reset.
- sample_count  out  ADDR_W+1  entries captured so far in this run.
- sig  out  16  running signature.
- rd_valid  out  1  trace entry available.
- rd_ready  in  1  downstream accepts the entry.
- rd_data  out  WIDTH  current trace entry; 0 when rd_valid=0.
- rd_last  out  1  qualifies the final entry; 0 when rd_valid=0.

Behaviour:
- Reset (async assert, takes effect regardless of clk): state=IDLE; busy, done, rd_valid, rd_last, rd_data, sig, sample_count, wr_ptr, rd_ptr all 0. Trace memory contents are don't-care.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE or DONE with arm=1:
  - Go to CAPTURE next cycle.
  - Latch N = num_samples; N=0 or N>DEPTH is clamped to DEPTH.
  - Clear wr_ptr, rd_ptr, sample_count, sig; clear done.
- CAPTURE, each edge with sample_en=1:
  - mem[wr_ptr] <= vec_in; wr_ptr++; sample_count++.
  - sig <= {sig[14:0], sig[15]} ^ zero-extended vec_in.
  - Cycles with sample_en=0 change nothing.
  - When the write makes sample_count == N, state goes to DRAIN on that same edge.
- arm is ignored in CAPTURE and DRAIN, with no effect on any state. sample_en is ignored outside CAPTURE.
- DRAIN:
  - rd_valid=1 from the first cycle after the final capture edge.
  - rd_data = mem[rd_ptr], combinational read.
  - rd_last = (rd_ptr == N-1).
  - Edge with rd_valid & rd_ready: rd_ptr++. If rd_last was set, go to DONE instead.
  - With rd_ready=0, rd_data and rd_last hold stable.
- DONE: done=1, busy=0, rd_valid=0. sig and sample_count hold their final values until the next arm.
- N=DEPTH: wr_ptr wraps to 0 after the last write. Completion is decided from sample_count (ADDR_W+1 bits), never from the pointer.
- Reset mid-CAPTURE or mid-DRAIN: immediate return to IDLE; the partial trace is discarded.
- Latency: a captured entry can be read at the earliest 1 cycle after its write edge, and only once all N entries are captured.

Decomposition:
- Package dff_trace_pkg:
  - state encoding enum (IDLE, CAPTURE, DRAIN, DONE);
  - field indices TRC_RST=3, TRC_EN=2, TRC_D=1, TRC_Q=0;
  - SIG_W=16.
- One sub-module, dff_trace_mem: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port, no reset. The FSM, counters and signature stay in the top.

Test Plan:
- Arm N=4; sample_en high for 4 cycles with vec_in 0101, 0110, 0011, 1000; rd_ready=1 -> busy=1 during the run; drain returns the same 4 values in order; rd_last only on 1000; then done=1, sample_count=4, sig=0x003E.
- Arm N=3; sample_en pattern 1,0,0,1,0,1 with vec_in changing every cycle -> only the 3 strobed values are stored and drained; state leaves CAPTURE on the 6th edge.
- Backpressure: during DRAIN hold rd_ready=0 for 3 cycles -> rd_valid=1 and rd_data/rd_last stable; each later ready cycle advances exactly one entry.
- num_samples=0 -> 16 entries (0000..1111 incrementing) captured and drained; rd_last on 1111; sample_count=16; no early DRAIN caused by wr_ptr wrap.
- Arm pulsed mid-CAPTURE -> ignored, count continues. Arm in DONE -> done=0 and sig=0 the next cycle, and a new run proceeds normally.
- Assert reset asynchronously mid-DRAIN (between clock edges) -> rd_valid, busy, done, sig, sample_count read 0 immediately; after release the block sits in IDLE until arm.

Source files
------------

// File: rtl/dff_trace_pkg.sv
// ---------------------------------------------------------------------------
// dff_trace_pkg
// Shared types and constants for the flip-flop trace recorder.
//   state_t      : recorder control states
//   TRC_*        : bit positions of the fields inside one trace entry
//   SIG_W        : width of the running signature
//   sigStep()    : one signature update (rotate left by one, xor new entry)
// ---------------------------------------------------------------------------
package dff_trace_pkg;

  // Recorder control states. DONE is separate from IDLE so that the
  // "done" flag and the final signature/count can be held for the reader.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Meaning of each bit in a snapshot of the flip-flop under test.
  localparam int TRC_RST = 3;
  localparam int TRC_EN  = 2;
  localparam int TRC_D   = 1;
  localparam int TRC_Q   = 0;

  localparam int SIG_W = 16;

  // The signature is a simple rotate-and-xor accumulator. The entry is
  // expected to be zero-extended to SIG_W bits by the caller.
  function automatic logic [SIG_W-1:0] sigStep(input logic [SIG_W-1:0] sigIn,
                                               input logic [SIG_W-1:0] entry);
    return {sigIn[SIG_W-2:0], sigIn[SIG_W-1]} ^ entry;
  endfunction

endpackage

// File: rtl/dff_trace_mem.sv
// ---------------------------------------------------------------------------
// dff_trace_mem
// DEPTH x WIDTH register array holding the captured trace.
//   i_clk     : write clock
//   i_wrEn    : write strobe, entry stored on the rising edge
//   i_wrAddr  : write address
//   i_wrData  : entry to store
//   i_rdAddr  : read address
//   o_rdData  : entry at i_rdAddr, combinational read
// The array has no reset: contents are only ever read after being written
// in the same run, so clearing them would buy nothing.
// ---------------------------------------------------------------------------
module dff_trace_mem #(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [WIDTH-1:0]  i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [WIDTH-1:0]  o_rdData
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  // Asynchronous read so the drain port presents data in the same cycle
  // the read pointer moves.
  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/dff_trace_capture.sv
// ---------------------------------------------------------------------------
// dff_trace_capture
// Records per-step snapshots of a flip-flop under test, then replays them
// in order over a valid/ready port. Also keeps a running 16-bit signature.
//
// Ports
//   i_clk          : clock, all state updates on the rising edge
//   i_reset        : asynchronous active-high reset, clears all state
//   i_arm          : single-cycle start request (honoured in IDLE/DONE only)
//   i_sampleEn     : marks the current cycle as a capture step
//   i_vecIn        : snapshot {dut reset, enable, d, q}
//   i_numSamples   : capture length, latched at arm (0 or >DEPTH -> DEPTH)
//   o_busy         : high while capturing or draining
//   o_done         : high in DONE, sticky until the next arm or reset
//   o_sampleCount  : entries captured in this run
//   o_sig          : running signature
//   o_rdValid      : a trace entry is being offered
//   i_rdReady      : downstream accepts the offered entry
//   o_rdData       : offered entry, 0 when o_rdValid is low
//   o_rdLast       : marks the final entry, 0 when o_rdValid is low
// ---------------------------------------------------------------------------
module dff_trace_capture
  import dff_trace_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_arm,
  input  logic              i_sampleEn,
  input  logic [WIDTH-1:0]  i_vecIn,
  input  logic [ADDR_W:0]   i_numSamples,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_sampleCount,
  output logic [SIG_W-1:0]  o_sig,
  output logic              o_rdValid,
  input  logic              i_rdReady,
  output logic [WIDTH-1:0]  o_rdData,
  output logic              o_rdLast
);

  // Counts are one bit wider than the pointers so that a full run of
  // DEPTH entries is representable; the pointers simply wrap.
  localparam logic [ADDR_W:0]   DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_sampleCount;
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [SIG_W-1:0]  r_sig;

  logic              w_armAccept;
  logic              w_wrEn;
  logic [ADDR_W:0]   w_countNext;
  logic [ADDR_W:0]   w_nClamped;
  logic              w_rdValid;
  logic              w_rdLast;
  logic              w_rdFire;
  logic [WIDTH-1:0]  w_memRdData;

  // Arm is only honoured when no run is in progress; in CAPTURE and DRAIN
  // it is dropped without touching any state.
  assign w_armAccept = i_arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Capture strobe is meaningful only while capturing.
  assign w_wrEn      = (r_state == ST_CAPTURE) && i_sampleEn;
  assign w_countNext = r_sampleCount + CNT_ONE;

  // A zero or oversized request means "fill the whole memory".
  assign w_nClamped  = ((i_numSamples == '0) || (i_numSamples > DEPTH_N))
                       ? DEPTH_N : i_numSamples;

  // Drain handshake. The last-entry flag compares the read pointer with
  // N-1 in the wider count domain so N == DEPTH works without overflow.
  assign w_rdValid = (r_state == ST_DRAIN);
  assign w_rdLast  = w_rdValid && ({1'b0, r_rdPtr} == (r_n - CNT_ONE));
  assign w_rdFire  = w_rdValid && i_rdReady;

  dff_trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .i_clk    (i_clk),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (r_wrPtr),
    .i_wrData (i_vecIn),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_memRdData)
  );

  // State register. Reset drops straight back to IDLE from any state,
  // discarding any partial run.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Completion of the capture phase is decided from the
  // sample count, never from the write pointer, because the pointer wraps
  // to zero on the final write of a full-depth run.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_armAccept) begin
          w_nextState = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_wrEn && (w_countNext == r_n)) begin
          w_nextState = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_rdFire && w_rdLast) begin
          w_nextState = ST_DONE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Run datapath: latched length, pointers, sample count and signature.
  // An accepted arm starts a fresh run; otherwise writes and reads advance
  // their own pointers. The read pointer is left alone on the final read
  // since the run ends there and the next arm clears it anyway.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_n           <= '0;
      r_sampleCount <= '0;
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_sig         <= '0;
    end else if (w_armAccept) begin
      r_n           <= w_nClamped;
      r_sampleCount <= '0;
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_sig         <= '0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr       <= r_wrPtr + PTR_ONE;
        r_sampleCount <= w_countNext;
        r_sig         <= sigStep(r_sig, SIG_W'(i_vecIn));
      end
      if (w_rdFire && !w_rdLast) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
    end
  end

  // Output decode. Read data and last flag are forced to zero outside
  // DRAIN so the reader never sees stale memory contents.
  always_comb begin
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_rdValid = 1'b0;
    o_rdData  = '0;
    o_rdLast  = 1'b0;
    unique case (r_state)
      ST_CAPTURE: begin
        o_busy = 1'b1;
      end
      ST_DRAIN: begin
        o_busy    = 1'b1;
        o_rdValid = w_rdValid;
        o_rdData  = w_memRdData;
        o_rdLast  = w_rdLast;
      end
      ST_DONE: begin
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_sampleCount = r_sampleCount;
  assign o_sig         = r_sig;

endmodule

// File: tb/tb_dff_trace_capture.sv
// ---------------------------------------------------------------------------
// tb_dff_trace_capture
// Self-checking bench for dff_trace_capture. Captured entries are pushed to
// a scoreboard queue as they are driven and popped as the drain port
// accepts them. Signature and count are tracked by a small model.
// ---------------------------------------------------------------------------
module tb_dff_trace_capture;
  import dff_trace_pkg::*;

  localparam int DEPTH  = 16;
  localparam int WIDTH  = 4;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              i_clk;
  logic              i_reset;
  logic              i_arm;
  logic              i_sampleEn;
  logic [WIDTH-1:0]  i_vecIn;
  logic [ADDR_W:0]   i_numSamples;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W:0]   o_sampleCount;
  logic [SIG_W-1:0]  o_sig;
  logic              o_rdValid;
  logic              i_rdReady;
  logic [WIDTH-1:0]  o_rdData;
  logic              o_rdLast;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] scoreQ[$];
  logic [SIG_W-1:0] expSig;
  int               expCount;

  dff_trace_capture #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_arm         (i_arm),
    .i_sampleEn    (i_sampleEn),
    .i_vecIn       (i_vecIn),
    .i_numSamples  (i_numSamples),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_sampleCount (o_sampleCount),
    .o_sig         (o_sig),
    .o_rdValid     (o_rdValid),
    .i_rdReady     (i_rdReady),
    .o_rdData      (o_rdData),
    .o_rdLast      (o_rdLast)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge; all driving and sampling
  // happens at these points, away from the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic armRun(input int n);
    i_arm        = 1'b1;
    i_numSamples = (ADDR_W+1)'(n);
    tick();
    i_arm    = 1'b0;
    expSig   = '0;
    expCount = 0;
  endtask

  // One capture cycle; strobed values go to the scoreboard and the model.
  task automatic applyStimulus(input bit en, input logic [WIDTH-1:0] vec);
    i_sampleEn = en;
    i_vecIn    = vec;
    if (en) begin
      scoreQ.push_back(vec);
      expSig = {expSig[SIG_W-2:0], expSig[SIG_W-1]} ^ SIG_W'(vec);
      expCount++;
    end
    tick();
    i_sampleEn = 1'b0;
  endtask

  // Drain the scoreboard. 'stall' ready-low cycles first; with 'alternate'
  // each accepted entry is preceded by one ready-low cycle.
  task automatic drainAll(input int stall, input bit alternate);
    int guard;
    guard = 0;
    i_rdReady = 1'b0;
    for (int k = 0; k < stall && scoreQ.size() > 0; k++) begin
      checkOutput("bp_valid", 32'(o_rdValid), 32'd1);
      checkOutput("bp_data",  32'(o_rdData),  32'(scoreQ[0]));
      checkOutput("bp_last",  32'(o_rdLast),  32'(scoreQ.size() == 1));
      tick();
    end
    while (scoreQ.size() > 0 && guard < 4 * DEPTH) begin
      guard++;
      if (alternate) begin
        i_rdReady = 1'b0;
        checkOutput("hold_data", 32'(o_rdData), 32'(scoreQ[0]));
        checkOutput("hold_last", 32'(o_rdLast), 32'(scoreQ.size() == 1));
        tick();
      end
      i_rdReady = 1'b1;
      checkOutput("rd_valid", 32'(o_rdValid), 32'd1);
      checkOutput("rd_data",  32'(o_rdData),  32'(scoreQ[0]));
      checkOutput("rd_last",  32'(o_rdLast),  32'(scoreQ.size() == 1));
      void'(scoreQ.pop_front());
      tick();
    end
    i_rdReady = 1'b0;
    checkOutput("drain_left", 32'(scoreQ.size()), 32'd0);
  endtask

  task automatic checkDone();
    checkOutput("done_done",  32'(o_done),        32'd1);
    checkOutput("done_busy",  32'(o_busy),        32'd0);
    checkOutput("done_valid", 32'(o_rdValid),     32'd0);
    checkOutput("done_data",  32'(o_rdData),      32'd0);
    checkOutput("done_last",  32'(o_rdLast),      32'd0);
    checkOutput("done_count", 32'(o_sampleCount), 32'(expCount));
    checkOutput("done_sig",   32'(o_sig),         32'(expSig));
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_busy"},  32'(o_busy),        32'd0);
    checkOutput({tag, "_done"},  32'(o_done),        32'd0);
    checkOutput({tag, "_valid"}, 32'(o_rdValid),     32'd0);
    checkOutput({tag, "_last"},  32'(o_rdLast),      32'd0);
    checkOutput({tag, "_data"},  32'(o_rdData),      32'd0);
    checkOutput({tag, "_sig"},   32'(o_sig),         32'd0);
    checkOutput({tag, "_count"}, 32'(o_sampleCount), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] t1Vec [4];
    logic [WIDTH-1:0] t2Vec [6];
    bit               t2En  [6];

    t1Vec = '{4'b0101, 4'b0110, 4'b0011, 4'b1000};
    t2Vec = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    t2En  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    i_reset      = 1'b1;
    i_arm        = 1'b0;
    i_sampleEn   = 1'b0;
    i_vecIn      = '0;
    i_numSamples = '0;
    i_rdReady    = 1'b0;
    expSig       = '0;
    expCount     = 0;

    #1;
    checkCleared("reset");
    tick();
    tick();
    #2 i_reset = 1'b0;
    tick();
    checkCleared("idle");

    // Run 1: N=4, four consecutive strobes, ready held high.
    $display("[TB] run 1: N=4 basic capture");
    armRun(4);
    checkOutput("t1_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, t1Vec[i]);
      checkOutput("t1_busy_run", 32'(o_busy), 32'd1);
      checkOutput("t1_valid_run", 32'(o_rdValid), 32'(i == 3));
    end
    drainAll(0, 1'b0);
    checkDone();
    checkOutput("t1_sig_const", 32'(o_sig), 32'h003E);

    // Run 2: N=3, sparse strobes, then backpressure on the drain.
    $display("[TB] run 2: N=3 sparse strobes with backpressure");
    armRun(3);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(t2En[i], t2Vec[i]);
      checkOutput("t2_valid_run", 32'(o_rdValid), 32'(i == 5));
    end
    checkOutput("t2_count", 32'(o_sampleCount), 32'd3);
    drainAll(3, 1'b1);
    checkDone();

    // Run 3: num_samples=0 -> full depth, pointer wraps on the last write.
    $display("[TB] run 3: N=0 clamps to full depth");
    armRun(0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, WIDTH'(i));
      checkOutput("t3_valid_run", 32'(o_rdValid), 32'(i == DEPTH - 1));
    end
    checkOutput("t3_count", 32'(o_sampleCount), 32'(DEPTH));
    drainAll(0, 1'b0);
    checkDone();

    // Run 4: arm pulsed mid-capture is ignored.
    $display("[TB] run 4: arm ignored during capture");
    armRun(5);
    applyStimulus(1'b1, 4'h3);
    applyStimulus(1'b1, 4'h7);
    i_arm        = 1'b1;
    i_numSamples = (ADDR_W+1)'(2);
    applyStimulus(1'b1, 4'hB);
    i_arm = 1'b0;
    checkOutput("t4_count_mid", 32'(o_sampleCount), 32'd3);
    checkOutput("t4_busy_mid",  32'(o_busy),        32'd1);
    checkOutput("t4_valid_mid", 32'(o_rdValid),     32'd0);
    applyStimulus(1'b1, 4'h1);
    checkOutput("t4_valid_4", 32'(o_rdValid), 32'd0);
    applyStimulus(1'b1, 4'hF);
    checkOutput("t4_valid_5", 32'(o_rdValid), 32'd1);
    drainAll(0, 1'b0);
    checkDone();

    // Arm from DONE clears done and signature on the next cycle.
    armRun(2);
    checkOutput("t5_done", 32'(o_done),        32'd0);
    checkOutput("t5_sig",  32'(o_sig),         32'd0);
    checkOutput("t5_count",32'(o_sampleCount), 32'd0);
    checkOutput("t5_busy", 32'(o_busy),        32'd1);
    applyStimulus(1'b1, 4'hC);
    applyStimulus(1'b1, 4'h5);
    drainAll(1, 1'b0);
    checkDone();

    // Run 6: asynchronous reset in the middle of a drain.
    $display("[TB] run 6: async reset mid-drain");
    armRun(4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, WIDTH'(4'hA - i));
    end
    i_rdReady = 1'b1;
    checkOutput("t6_rd_data0", 32'(o_rdData), 32'(scoreQ[0]));
    void'(scoreQ.pop_front());
    tick();
    i_rdReady = 1'b0;
    checkOutput("t6_rd_data1", 32'(o_rdData), 32'(scoreQ[0]));
    #2 i_reset = 1'b1;
    #1;
    checkCleared("t6_async");
    scoreQ.delete();
    tick();
    #2 i_reset = 1'b0;
    i_sampleEn = 1'b1;
    i_vecIn    = 4'hF;
    tick();
    tick();
    i_sampleEn = 1'b0;
    checkCleared("t6_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
